xor5_frame_checker: RTL and testbench

Downstream consumer of the 5-input parity stage. Receives each 5-bit operand vector together with the parity bit the xor5 stage produced for it. Recomputes and checks that parity per symbol, accumulates frame parity, mismatch count and length over a frame, then emits one registered frame report through a valid/ready handshake. Sits between the parity stage and the frame sink or scoreboard.

---
 rtl/xor5_frame_checker.sv | 163 ++++++++++++++++
 tb/tb_xor5_frame_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor5_frame_checker.sv
// xor5_frame_checker
// Consumes {operand vector, parity} pairs from the xor5 parity stage,
// recomputes the parity of every symbol, and accumulates frame parity,
// mismatch count and length over a frame. One registered frame report
// is then offered on a valid/ready output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds valid (and data) until ready; the
// consumer may raise or lower ready freely. in_ready depends only on
// registered state (and rst), never on in_valid.
//
// Optional feature macro: XOR5_CHK_STICKY_EN
//   defined   -> out_sticky_err latches on the handshake of any report
//                carrying a symbol error or an overflow; cleared by rst.
//   undefined -> out_sticky_err is constant 0 and costs no flop.
module xor5_frame_checker #(
    parameter int MAX_LEN = 64,
    parameter int LW      = 7,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_sym,
    input  logic          in_par,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_frame_par,
    output logic [CW-1:0] out_err_cnt,
    output logic          out_sym_err,
    output logic [LW-1:0] out_len,
    output logic          out_overflow,
    output logic          out_sticky_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t        state_q;
    logic          valid_q;
    logic          par_q;
    logic [CW-1:0] err_q;
    logic [LW-1:0] len_q;
    logic          ovf_q;

    logic          sym_par;
    logic          mismatch;
    logic          par_d;
    logic [CW-1:0] err_d;
    logic [LW-1:0] len_d;
    logic          len_at_max;
    logic          handshake;

    // Per-symbol parity check and the accumulator values an ACCUM accept would load
    always_comb begin
        sym_par    = ^in_sym;
        mismatch   = sym_par ^ in_par;
        par_d      = par_q ^ sym_par;
        len_d      = len_q + 1'b1;
        len_at_max = (len_d == LW'(MAX_LEN));
        if (mismatch && (err_q != {CW{1'b1}})) begin
            err_d = err_q + 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Ready is a pure function of the registered state, held low through reset
    assign in_ready  = ~rst & (state_q != S_REPORT);
    assign handshake = valid_q & out_ready;

    // Frame FSM: IDLE loads the first symbol, ACCUM adds, REPORT holds until drained
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        par_q <= sym_par;
                        err_q <= CW'(mismatch);
                        len_q <= LW'(1);
                        if (in_last || (MAX_LEN == 1)) begin
                            state_q <= S_REPORT;
                            valid_q <= 1'b1;
                            ovf_q   <= ~in_last;
                        end else begin
                            state_q <= S_ACCUM;
                            ovf_q   <= 1'b0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        par_q <= par_d;
                        err_q <= err_d;
                        len_q <= len_d;
                        if (in_last) begin
                            state_q <= S_REPORT;
                            valid_q <= 1'b1;
                            ovf_q   <= 1'b0;
                        end else if (len_at_max) begin
                            state_q <= S_REPORT;
                            valid_q <= 1'b1;
                            ovf_q   <= 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        par_q   <= 1'b0;
                        err_q   <= '0;
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid     = valid_q;
    assign out_frame_par = par_q;
    assign out_err_cnt   = err_q;
    assign out_sym_err   = (err_q != '0);
    assign out_len       = len_q;
    assign out_overflow  = ovf_q;
    assign dbg_state     = state_q;

`ifdef XOR5_CHK_STICKY_EN
    logic sticky_q;

    // Sticky flag latches when a faulty or overflowed report is handed off
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (handshake && ((err_q != '0) || ovf_q)) begin
            sticky_q <= 1'b1;
        end
    end

    assign out_sticky_err = sticky_q;
`else
    assign out_sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_xor5_frame_checker.sv
// Bench for xor5_frame_checker: three instances (default, MAX_LEN=4,
// CW=2). Reports are predicted from per-frame bookkeeping and compared
// when the sink takes them.
module tb_xor5_frame_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid[3];
  logic       in_ready[3];
  logic [4:0] in_sym[3];
  logic       in_par[3];
  logic       in_last[3];
  logic       out_valid[3];
  logic       out_ready[3];
  logic       fp_o[3];
  logic       sym_err_o[3];
  logic [6:0] len_o[3];
  logic       ovf_o[3];
  logic       sticky_o[3];
  logic [1:0] dbg_o[3];
  logic [7:0] err_a;
  logic [7:0] err_b;
  logic [1:0] err_c;

  int checks = 0;
  int errors = 0;
  logic rand_bp = 1'b0;

  // model: open-frame bookkeeping per instance
  int   m_len[3];
  int   m_err[3];
  logic m_par[3];
  int   max_len[3] = '{64, 4, 64};
  int   err_max[3] = '{255, 255, 3};
  logic exp_sticky[3];
  // report packing: {inst[1:0], ovf, len[6:0], err[7:0], frame_par, sym_err}
  logic [19:0] exp_q[$];

  xor5_frame_checker dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_sym(in_sym[0]), .in_par(in_par[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_frame_par(fp_o[0]),
    .out_err_cnt(err_a), .out_sym_err(sym_err_o[0]), .out_len(len_o[0]),
    .out_overflow(ovf_o[0]), .out_sticky_err(sticky_o[0]), .dbg_state(dbg_o[0])
  );

  xor5_frame_checker #(.MAX_LEN(4), .LW(7), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_sym(in_sym[1]), .in_par(in_par[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_frame_par(fp_o[1]),
    .out_err_cnt(err_b), .out_sym_err(sym_err_o[1]), .out_len(len_o[1]),
    .out_overflow(ovf_o[1]), .out_sticky_err(sticky_o[1]), .dbg_state(dbg_o[1])
  );

  xor5_frame_checker #(.MAX_LEN(64), .LW(7), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_sym(in_sym[2]), .in_par(in_par[2]), .in_last(in_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_frame_par(fp_o[2]),
    .out_err_cnt(err_c), .out_sym_err(sym_err_o[2]), .out_len(len_o[2]),
    .out_overflow(ovf_o[2]), .out_sticky_err(sticky_o[2]), .dbg_state(dbg_o[2])
  );

  function automatic logic [7:0] err_of(input int k);
    case (k)
      0:       return err_a;
      1:       return err_b;
      default: return {6'b0, err_c};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      m_len[k] = 0;
      m_err[k] = 0;
      m_par[k] = 1'b0;
    end
  endtask

  // Hold rst for 'cycles' edges, check the cleared outputs, release
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_valid", out_valid[k], 0);
      chk("rst_fp", fp_o[k], 0);
      chk("rst_err", err_of(k), 0);
      chk("rst_sym_err", sym_err_o[k], 0);
      chk("rst_len", len_o[k], 0);
      chk("rst_ovf", ovf_o[k], 0);
      chk("rst_sticky", sticky_o[k], 0);
    end
    rst = 1'b0;
    clear_model();
  endtask

  // Offer one symbol, wait for acceptance, update the frame model
  task automatic send(input int k, input logic [4:0] sym, input logic par, input logic last);
    int waited;
    logic p;
    int e;
    waited = 0;
    in_valid[k] = 1'b1;
    in_sym[k]   = sym;
    in_par[k]   = par;
    in_last[k]  = last;
    @(negedge clk);
    while (in_ready[k] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", (waited < 200), 1);
    if (waited >= 200) begin
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    p = ^sym;
    m_par[k] = m_par[k] ^ p;
    m_err[k] = m_err[k] + ((p != par) ? 1 : 0);
    m_len[k] = m_len[k] + 1;
    if (last || m_len[k] == max_len[k]) begin
      e = (m_err[k] > err_max[k]) ? err_max[k] : m_err[k];
      exp_q.push_back({2'(k), ~last, 7'(m_len[k]), 8'(e), m_par[k], (e != 0)});
      chk("latency_valid", out_valid[k], 1);
      m_len[k] = 0;
      m_err[k] = 0;
      m_par[k] = 1'b0;
    end else begin
      chk("open_no_valid", out_valid[k], 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Sink-side monitor: report content, in_ready while reporting, sticky flag
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        exp_sticky[k] = 1'b0;
      end else begin
        chk("sticky", sticky_o[k], exp_sticky[k]);
        if (out_valid[k] === 1'b1) chk("ready_low_in_report", in_ready[k], 0);
        if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
          chk("report_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            logic [19:0] got;
            logic [19:0] exp;
            exp = exp_q.pop_front();
            got = {2'(k), ovf_o[k], len_o[k], err_of(k), fp_o[k], sym_err_o[k]};
            chk("report", got, exp);
`ifdef XOR5_CHK_STICKY_EN
            if (exp[17] || exp[0]) exp_sticky[k] = 1'b1;
`endif
          end
        end
      end
    end
  end

  // Random backpressure on instance 0 during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_bp) out_ready[0] = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int flen;
    logic [4:0] s;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_sym[k]    = 5'd0;
      in_par[k]    = 1'b0;
      in_last[k]   = 1'b0;
      out_ready[k] = 1'b1;
    end
    clear_model();
    do_reset(3);

    // clean frame: expect frame_par=0, err=0, len=3
    send(0, 5'b10110, 1'b1, 1'b0);
    send(0, 5'b00011, 1'b0, 1'b0);
    send(0, 5'b11111, 1'b1, 1'b1);
    #1;
    chk("clean_fp", fp_o[0], 0);
    chk("clean_len", len_o[0], 3);
    drain();

    // two mismatches in a frame, then a clean frame
    send(0, 5'b01000, 1'b0, 1'b0);
    send(0, 5'b00000, 1'b0, 1'b0);
    send(0, 5'b11100, 1'b0, 1'b1);
    #1;
    chk("mis_err", err_a, 2);
    chk("mis_sym_err", sym_err_o[0], 1);
    drain();
    send(0, 5'b00000, 1'b0, 1'b1);
    drain();

    // backpressure: report held while the sink stalls
    out_ready[0] = 1'b0;
    send(0, 5'b00001, 1'b1, 1'b1);
    in_valid[0] = 1'b1;
    in_sym[0]   = 5'b10101;
    in_par[0]   = 1'b1;
    in_last[0]  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_valid", out_valid[0], 1);
      chk("bp_fp", fp_o[0], 1);
      chk("bp_len", len_o[0], 1);
    end
    out_ready[0] = 1'b1;
    send(0, 5'b10101, 1'b1, 1'b1);
    drain();

    // overflow on MAX_LEN=4: reports len 4 (overflow) then len 2
    for (int i = 0; i < 6; i++) send(1, 5'b00000, 1'b0, (i == 5));
    drain();

    // reset in the middle of a frame discards it
    send(0, 5'b00110, 1'b0, 1'b0);
    send(0, 5'b01110, 1'b1, 1'b0);
    do_reset(1);
    send(0, 5'b00001, 1'b1, 1'b1);
    drain();

    // mismatch counter saturation on CW=2
    for (int i = 0; i < 5; i++) send(2, 5'b00001, 1'b0, (i == 4));
    drain();

    // random frames with random sink stalls, including MAX_LEN closes
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      flen = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 70) : $urandom_range(1, 8);
      for (int i = 0; i < flen; i++) begin
        s = 5'($urandom_range(0, 31));
        send(0, s, (^s) ^ ($urandom_range(0, 3) == 0), (i == flen - 1));
        if ($urandom_range(0, 4) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    rand_bp = 1'b0;
    #3;
    out_ready[0] = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
